refclk_strobe_gen: RTL and testbench
====================================

Name: refclk_strobe_gen

Overview:
- Synchronizes an asynchronous 32.768 kHz reference clock into the i_clk domain and detects its rising edges.
- Divides the detected edges into single-cycle timing strobes: a 1 Hz timekeeping strobe, plus slow and fast strobes used for time-setting auto-repeat.
- Sits between the board refclk pin and the clock/time-set logic of the 7-segment clock.

Parameters:
- REFCLK_HZ, 32768: refclk edges per second; divisor for the 1 Hz strobe.
- SLOW_SET_HZ, 2: slow-set strobe rate. REFCLK_HZ must be an exact multiple of it.
- FAST_SET_HZ, 8: fast-set strobe rate. REFCLK_HZ must be an exact multiple of it.

Ports:
- i_clk  input  1  system clock (12.5 MHz nominal); all logic is on its rising edge.
- i_reset_n  input  1  reset; synchronous, active-low.
- i_refclk  input  1  asynchronous reference clock, 32.768 kHz nominal.
- o_1hz_stb  output  1  one-i_clk-cycle pulse, once per REFCLK_HZ refclk rising edges.
- o_slow_set_stb  output  1  one-cycle pulse, once per REFCLK_HZ/SLOW_SET_HZ edges.
- o_fast_set_stb  output  1  one-cycle pulse, once per REFCLK_HZ/FAST_SET_HZ edges.
- o_refclk_sync  output  1  synchronized refclk (stage-2 value), for debug and downstream use.

Behaviour:
- Clocking and reset:
  - Single clock domain, i_clk. Reset is synchronous, active-low.
  - While i_reset_n=0 at a rising edge, every register clears to 0, including all outputs.
- Synchronizer:
  - Two flops, i_refclk -> s1 -> s2. o_refclk_sync = s2.
- Edge detect:
  - Register prev <= s2. Edge pulse = s2 & ~prev (combinational, internal).
- Counters: three independent up-counters, each clog2(divisor) bits wide:
  - cnt_1hz, divisor REFCLK_HZ (15 bits at the default).
  - cnt_slow, divisor REFCLK_HZ/SLOW_SET_HZ.
  - cnt_fast, divisor REFCLK_HZ/FAST_SET_HZ.
- Counting rule, per counter, on an edge pulse:
  - If cnt == divisor-1: cnt <= 0 and the matching output strobe is registered to 1.
  - Otherwise: cnt <= cnt+1 and the strobe is registered to 0.
- With no edge pulse, counters hold and all strobes are registered to 0.
- Strobes are registered outputs and are never high on two consecutive i_clk cycles.
- Latency: if i_refclk is first sampled high at i_clk edge k, the edge pulse occurs after edge k+1 and the strobe is high for exactly the cycle between edges k+2 and k+3.
- Alignment:
  - Because divisors nest, o_1hz_stb coincides with an o_slow_set_stb and an o_fast_set_stb pulse.
  - Each o_slow_set_stb coincides with an o_fast_set_stb pulse.
- First strobes after reset release:
  - o_fast_set_stb: 4096th refclk rising edge.
  - o_slow_set_stb: 16384th edge.
  - o_1hz_stb: 32768th edge.
- Refclk high at reset release: s1/s2/prev are 0, so it is counted as a rising edge (deterministic).
- Refclk stopped high or low: no edge pulses, counters hold, no strobes.
- Reset mid-count: counters return to 0; the next 1 Hz strobe is a full REFCLK_HZ edges after release.
- Refclk must satisfy i_clk > 4 × refclk frequency so that every refclk high and low phase is sampled at least twice.

Optional Feature:
- Macro: REFCLK_STROBE_SIM_SPEEDUP_EN.
- When defined: every divisor is divided by 256, giving:
  - 1 Hz strobe every 128 edges.
  - Slow strobe every 64 edges.
  - Fast strobe every 16 edges.
  - Counter widths shrink accordingly.
- When undefined: full divisors as above.
- Synchronizer, edge detect, latency and alignment are unchanged in both cases.

Test Plan:
- Reset hold: i_clk 80 ns, refclk toggling, i_reset_n=0 for 2 cycles -> all outputs 0 throughout.
- Nominal timing: refclk period 3051 ns, release reset, wait for two o_1hz_stb pulses:
  - Each pulse is exactly 1 cycle (80 ns) wide.
  - Spacing is 32768 refclk periods (~99.97 ms).
  - First pulse follows the 32768th refclk rising edge.
- Strobe counts between consecutive o_1hz_stb pulses:
  - Exactly 8 o_fast_set_stb and 2 o_slow_set_stb.
  - Both are also high in the same cycle as o_1hz_stb.
- Latency: single refclk rising edge after a counter preload near wrap -> strobe high exactly in the cycle after the 3rd i_clk edge sampling i_refclk high.
- Stalled refclk: hold i_refclk high for 1 ms, then low for 1 ms -> no strobes, counters unchanged. Resume toggling and counting continues from the held value.
- Mid-count reset: assert i_reset_n=0 for 1 cycle after 20000 edges -> next o_1hz_stb after 32768 further edges. With REFCLK_STROBE_SIM_SPEEDUP_EN defined, o_1hz_stb every 128 edges.

Source files
------------

// File: rtl/refclk_strobe_gen.sv
// -----------------------------------------------------------------------------
// refclk_strobe_gen
//
// Purpose:
//   Brings the asynchronous 32.768 kHz board reference clock into the clk
//   domain through a two-flop synchronizer. It detects rising edges of the
//   synchronized signal. It divides those edges into three single-cycle timing
//   strobes:
//     - a 1 Hz timekeeping strobe
//     - a slow strobe for time-set auto-repeat
//     - a fast strobe for time-set auto-repeat
//
// Ports:
//   i_clk           in   system clock; all logic runs on its rising edge
//   i_reset_n       in   synchronous, active-low reset
//   i_refclk        in   asynchronous reference clock
//   o_1hz_stb       out  one-cycle pulse every REFCLK_HZ refclk rising edges
//   o_slow_set_stb  out  one-cycle pulse every REFCLK_HZ/SLOW_SET_HZ edges
//   o_fast_set_stb  out  one-cycle pulse every REFCLK_HZ/FAST_SET_HZ edges
//   o_refclk_sync   out  synchronized refclk (second synchronizer stage)
//
// Build option:
//   REFCLK_STROBE_SIM_SPEEDUP_EN
//     When defined, every divisor is divided by 256. The 1 Hz, slow and fast
//     strobes then come every 128, 64 and 16 edges at the default rates.
//     The synchronizer, edge detect, latency and alignment do not change.
//
// Timing:
//   If i_refclk is first sampled high at clk edge k, the edge pulse follows
//   edge k+1. Any strobe it produces is high between edges k+2 and k+3.
//   i_clk must run faster than 4x the refclk frequency.
// -----------------------------------------------------------------------------
module refclk_strobe_gen #(
  parameter int REFCLK_HZ   = 32768,
  parameter int SLOW_SET_HZ = 2,
  parameter int FAST_SET_HZ = 8
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_refclk,
  output logic o_1hz_stb,
  output logic o_slow_set_stb,
  output logic o_fast_set_stb,
  output logic o_refclk_sync
);

`ifdef REFCLK_STROBE_SIM_SPEEDUP_EN
  localparam int SPEEDUP = 256;
`else
  localparam int SPEEDUP = 1;
`endif

  localparam int DIV_1HZ  = REFCLK_HZ / SPEEDUP;
  localparam int DIV_SLOW = (REFCLK_HZ / SLOW_SET_HZ) / SPEEDUP;
  localparam int DIV_FAST = (REFCLK_HZ / FAST_SET_HZ) / SPEEDUP;

  // Keep each counter at least one bit wide so a divisor of 1 still elaborates.
  localparam int W_1HZ  = (DIV_1HZ  > 1) ? $clog2(DIV_1HZ)  : 1;
  localparam int W_SLOW = (DIV_SLOW > 1) ? $clog2(DIV_SLOW) : 1;
  localparam int W_FAST = (DIV_FAST > 1) ? $clog2(DIV_FAST) : 1;

  localparam logic [W_1HZ-1:0]  TOP_1HZ  = W_1HZ'(DIV_1HZ - 1);
  localparam logic [W_SLOW-1:0] TOP_SLOW = W_SLOW'(DIV_SLOW - 1);
  localparam logic [W_FAST-1:0] TOP_FAST = W_FAST'(DIV_FAST - 1);

  logic              sync_s1;
  logic              sync_s2;
  logic              sync_prev;
  logic              edge_pulse;
  logic [W_1HZ-1:0]  cnt_1hz;
  logic [W_SLOW-1:0] cnt_slow;
  logic [W_FAST-1:0] cnt_fast;

  // The previous value is 0 out of reset. A refclk that is already high at
  // reset release therefore counts as one rising edge, which keeps the count
  // deterministic.
  assign edge_pulse    = sync_s2 & ~sync_prev;
  assign o_refclk_sync = sync_s2;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      sync_s1   <= 1'b0;
      sync_s2   <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_s1   <= i_refclk;
      sync_s2   <= sync_s1;
      sync_prev <= sync_s2;
    end
  end

  // The three counters run independently. The divisors nest, so the slower
  // strobes land on the same cycle as a faster strobe.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      cnt_1hz   <= '0;
      o_1hz_stb <= 1'b0;
    end else if (edge_pulse) begin
      if (cnt_1hz == TOP_1HZ) begin
        cnt_1hz   <= '0;
        o_1hz_stb <= 1'b1;
      end else begin
        cnt_1hz   <= cnt_1hz + 1'b1;
        o_1hz_stb <= 1'b0;
      end
    end else begin
      o_1hz_stb <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      cnt_slow       <= '0;
      o_slow_set_stb <= 1'b0;
    end else if (edge_pulse) begin
      if (cnt_slow == TOP_SLOW) begin
        cnt_slow       <= '0;
        o_slow_set_stb <= 1'b1;
      end else begin
        cnt_slow       <= cnt_slow + 1'b1;
        o_slow_set_stb <= 1'b0;
      end
    end else begin
      o_slow_set_stb <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      cnt_fast       <= '0;
      o_fast_set_stb <= 1'b0;
    end else if (edge_pulse) begin
      if (cnt_fast == TOP_FAST) begin
        cnt_fast       <= '0;
        o_fast_set_stb <= 1'b1;
      end else begin
        cnt_fast       <= cnt_fast + 1'b1;
        o_fast_set_stb <= 1'b0;
      end
    end else begin
      o_fast_set_stb <= 1'b0;
    end
  end

endmodule

// File: tb/tb_refclk_strobe_gen.sv
// -----------------------------------------------------------------------------
// tb_refclk_strobe_gen
//
// Drives refclk edges with directed sequences. A reference edge counter
// predicts every strobe: which strobe bits are set and the clk cycle they
// should appear on. Each prediction goes into an expected queue. A monitor
// pops an entry each time any strobe is high and compares it.
//
// The divisors are reduced to 128 / 64 / 16 edges so the runs stay short.
// Without the speedup macro, REFCLK_HZ is overridden to 128. With the macro,
// the default 32768 is divided internally by 256.
// -----------------------------------------------------------------------------
module tb_refclk_strobe_gen;

`ifdef REFCLK_STROBE_SIM_SPEEDUP_EN
  localparam int P_REFCLK = 32768;
`else
  localparam int P_REFCLK = 128;
`endif
  localparam int DIV_1HZ  = 128;
  localparam int DIV_SLOW = 64;
  localparam int DIV_FAST = 16;
  localparam int W        = 35;  // {1hz, slow, fast, cycle[31:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  logic refclk;
  logic o_1hz_stb, o_slow_set_stb, o_fast_set_stb, o_refclk_sync;

  always #40 clk = ~clk;  // 80 ns period

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  refclk_strobe_gen #(
    .REFCLK_HZ  (P_REFCLK),
    .SLOW_SET_HZ(2),
    .FAST_SET_HZ(8)
  ) dut (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .i_refclk      (refclk),
    .o_1hz_stb     (o_1hz_stb),
    .o_slow_set_stb(o_slow_set_stb),
    .o_fast_set_stb(o_fast_set_stb),
    .o_refclk_sync (o_refclk_sync)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int model_cnt = 0;
  int n_1hz_exp = 0;
  int n_1hz_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Called when refclk goes high at the negedge whose cycle count is c. The
  // first sampling posedge is c+1. The pulse follows c+2. The strobe is seen
  // at the negedge with count c+3.
  task automatic note_edge(input int unsigned c);
    logic one, slow, fast;
    model_cnt++;
    one  = (model_cnt % DIV_1HZ)  == 0;
    slow = (model_cnt % DIV_SLOW) == 0;
    fast = (model_cnt % DIV_FAST) == 0;
    if (one) n_1hz_exp++;
    if (one | slow | fast) exp_q.push_back({one, slow, fast, 32'(c + 3)});
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_edge();
    refclk = 1'b1;
    note_edge(cyc);
    tick(2);
    check("sync_high", 32'(o_refclk_sync), 1);
    refclk = 1'b0;
    tick(2);
    check("sync_low", 32'(o_refclk_sync), 0);
  endtask

  task automatic drive_edges(input int n);
    for (int i = 0; i < n; i++) drive_edge();
  endtask

  // ---------------- monitor ----------------
  logic [2:0]   stb;
  logic [2:0]   prev_stb = 3'b000;
  logic [W-1:0] e;

  always @(negedge clk) begin
    stb = {o_1hz_stb, o_slow_set_stb, o_fast_set_stb};
    // An expected strobe whose cycle has passed was missed.
    while (exp_q.size() > 0 && exp_q[0][31:0] < cyc) begin
      e = exp_q.pop_front();
      check("missed_strobe_cycle", cyc, e[31:0]);
    end
    if (stb != 3'b000) begin
      if (o_1hz_stb) n_1hz_seen++;
      check("no_back_to_back", 32'(prev_stb != 3'b000), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 32'(stb), 0);
      end else begin
        e = exp_q.pop_front();
        check("strobe_bits", 32'(stb), 32'(e[34:32]));
        check("strobe_cycle", cyc, e[31:0]);
      end
      if (o_1hz_stb) check("1hz_align", 32'({o_slow_set_stb, o_fast_set_stb}), 3);
      if (o_slow_set_stb) check("slow_align", 32'(o_fast_set_stb), 1);
    end
    prev_stb = stb;
  end

  task automatic report();
    $display("%0d/%0d checks passed", n_pass, n_checks);
  endtask

  // Hard bound on the whole run.
  initial begin
    #(80 * 60000);
    $display("FAIL watchdog: run exceeded 60000 cycles at cycle %0d", cyc);
    n_checks++;
    report();
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    refclk  = 1'b0;
    // Reset hold: refclk toggling, every output must stay 0.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      refclk = ~refclk;
      check("reset_outputs",
            32'({o_1hz_stb, o_slow_set_stb, o_fast_set_stb, o_refclk_sync}), 0);
    end
    refclk = 1'b0;
    tick(2);
    reset_n = 1'b1;
    model_cnt = 0;

    // Nominal run: two full 1 Hz periods, with nested slow/fast strobes.
    drive_edges(2 * DIV_1HZ);

    // Mid-count reset after 20 edges; the next 1 Hz needs a full 128 edges.
    drive_edges(20);
    reset_n = 1'b0;
    model_cnt = 0;
    tick(1);
    reset_n = 1'b1;
    drive_edges(DIV_1HZ);

    // Stalled refclk high, then low. The counters hold, then resume.
    drive_edges(50);
    refclk = 1'b1;
    note_edge(cyc);
    tick(12500);
    check("stall_sync_high", 32'(o_refclk_sync), 1);
    refclk = 1'b0;
    tick(12500);
    check("stall_sync_low", 32'(o_refclk_sync), 0);
    // Edges 52..128 complete the period; edge 128 is a near-wrap latency check.
    drive_edges(DIV_1HZ - 51);
    drive_edges(10);

    // Refclk high across reset release counts as the first edge.
    reset_n = 1'b0;
    refclk  = 1'b1;
    model_cnt = 0;
    tick(3);
    check("reset_high_outputs",
          32'({o_1hz_stb, o_slow_set_stb, o_fast_set_stb, o_refclk_sync}), 0);
    reset_n = 1'b1;
    note_edge(cyc);
    tick(2);
    refclk = 1'b0;
    tick(2);
    drive_edges(DIV_FAST - 1);

    tick(10);
    check("queue_empty", 32'(exp_q.size()), 0);
    check("1hz_total", 32'(n_1hz_seen), 32'(n_1hz_exp));
    report();
    $finish;
  end

endmodule
